// File: rtl/wowa_sar_sequencer_if.sv
// Bus between the wowa SAR sequencer and its surroundings.
//   master: drives the requests and the comparator output, observes the controls and results
//   slave : the sequencer itself
// Signals:
//   start, calib_req, use_ext_thresh : conversion and calibration requests and mode select
//   comp_out                         : raw asynchronous comparator output
//   dac_set, thresh_sel, do_calibrate, comp_nen : analog front-end controls
//   busy, result, result_ready       : conversion status and corrected result
//   cal_offset, cal_valid            : stored calibration code and its valid flag
interface wowa_sar_sequencer_if;
    logic       start;
    logic       calib_req;
    logic       use_ext_thresh;
    logic       comp_out;
    logic [7:0] dac_set;
    logic       thresh_sel;
    logic       do_calibrate;
    logic       comp_nen;
    logic       busy;
    logic [7:0] result;
    logic       result_ready;
    logic [7:0] cal_offset;
    logic       cal_valid;

    modport master (
        output start, calib_req, use_ext_thresh, comp_out,
        input  dac_set, thresh_sel, do_calibrate, comp_nen, busy,
        input  result, result_ready, cal_offset, cal_valid
    );

    modport slave (
        input  start, calib_req, use_ext_thresh, comp_out,
        output dac_set, thresh_sel, do_calibrate, comp_nen, busy,
        output result, result_ready, cal_offset, cal_valid
    );
endinterface

// File: rtl/wowa_sar_sequencer.sv
// Successive-approximation conversion controller for the wowa analog front end.
// Sequences comparator warm-up, eight SAR bit phases per conversion, averaging over
// 2^AVG_LOG2 conversions, offset calibration and a one-phase external-threshold mode.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of wowa_sar_sequencer_if (requests, comparator, DAC/control
//              outputs, result and calibration status)
module wowa_sar_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned AVG_LOG2      = 2
) (
    input logic                 clk,
    input logic                 rst,
    wowa_sar_sequencer_if.slave bus
);

    localparam int unsigned AccW = 8 + AVG_LOG2;
    localparam int unsigned CntW = AVG_LOG2 + 1;
    localparam logic [CntW-1:0] LastConv   = CntW'((1 << AVG_LOG2) - 1);
    localparam logic [7:0]      SettleLast = 8'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StWarmup,
        StBit,
        StAccum,
        StExt,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              comp_meta_q, comp_sync_q;
    logic [7:0]        phase_q, phase_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        code_q, code_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   conv_q, conv_d;
    logic              cal_run_q, cal_run_d;
    logic              ext_q, ext_d;
    logic [7:0]        result_q, result_d;
    logic              ready_q, ready_d;
    logic [7:0]        cal_offset_q, cal_offset_d;
    logic              cal_valid_q, cal_valid_d;

    logic              phase_last;
    logic [7:0]        bit_mask;
    logic [7:0]        avg;
    logic [9:0]        corr;
    logic [7:0]        corr_sat;

    assign phase_last = (phase_q == SettleLast);
    assign bit_mask   = 8'd1 << bit_q;

    // External runs keep their single comparator sample in code_q.
    assign avg = ext_q ? code_q : 8'(acc_q >> AVG_LOG2);

    // avg - cal_offset + 0x80 spans -127..383, so 10 bits hold it in two's complement.
    assign corr = {2'b00, avg} - {2'b00, cal_offset_q} + 10'h080;

    always_comb begin
        corr_sat = corr[7:0];
        if (corr[9]) begin
            corr_sat = 8'h00;
        end else if (corr[8]) begin
            corr_sat = 8'hFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_meta_q  <= 1'b0;
            comp_sync_q  <= 1'b0;
            state_q      <= StIdle;
            phase_q      <= 8'h00;
            bit_q        <= 3'd0;
            code_q       <= 8'h00;
            acc_q        <= '0;
            conv_q       <= '0;
            cal_run_q    <= 1'b0;
            ext_q        <= 1'b0;
            result_q     <= 8'h00;
            ready_q      <= 1'b0;
            cal_offset_q <= 8'h80;
            cal_valid_q  <= 1'b0;
        end else begin
            comp_meta_q  <= bus.comp_out;
            comp_sync_q  <= comp_meta_q;
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            code_q       <= code_d;
            acc_q        <= acc_d;
            conv_q       <= conv_d;
            cal_run_q    <= cal_run_d;
            ext_q        <= ext_d;
            result_q     <= result_d;
            ready_q      <= ready_d;
            cal_offset_q <= cal_offset_d;
            cal_valid_q  <= cal_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q + 8'd1;
        bit_d        = bit_q;
        code_d       = code_q;
        acc_d        = acc_q;
        conv_d       = conv_q;
        cal_run_d    = cal_run_q;
        ext_d        = ext_q;
        result_d     = result_q;
        ready_d      = 1'b0;
        cal_offset_d = cal_offset_q;
        cal_valid_d  = cal_valid_q;
        bus.dac_set  = 8'h00;
        bus.comp_nen = 1'b1;

        unique case (state_q)
            StIdle: begin
                phase_d = 8'h00;
                if (bus.calib_req) begin
                    cal_run_d = 1'b1;
                    ext_d     = 1'b0;
                    state_d   = StWarmup;
                end else if (bus.start) begin
                    cal_run_d = 1'b0;
                    ext_d     = bus.use_ext_thresh;
                    state_d   = StWarmup;
                end
            end
            StWarmup: begin
                bus.comp_nen = 1'b0;
                if (phase_last) begin
                    phase_d = 8'h00;
                    bit_d   = 3'd7;
                    code_d  = 8'h00;
                    state_d = ext_q ? StExt : StBit;
                end
            end
            StBit: begin
                bus.comp_nen = 1'b0;
                bus.dac_set  = code_q | bit_mask;
                if (phase_last) begin
                    phase_d = 8'h00;
                    if (comp_sync_q) begin
                        code_d = code_q | bit_mask;
                    end
                    if (bit_q == 3'd0) begin
                        state_d = StAccum;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            StAccum: begin
                bus.comp_nen = 1'b0;
                acc_d        = acc_q + AccW'(code_q);
                conv_d       = conv_q + CntW'(1);
                phase_d      = 8'h00;
                if (conv_q == LastConv) begin
                    state_d = StDone;
                end else begin
                    bit_d   = 3'd7;
                    code_d  = 8'h00;
                    state_d = StBit;
                end
            end
            StExt: begin
                bus.comp_nen = 1'b0;
                if (phase_last) begin
                    phase_d = 8'h00;
                    code_d  = {7'b0, comp_sync_q};
                    state_d = StDone;
                end
            end
            StDone: begin
                if (cal_run_q) begin
                    cal_offset_d = avg;
                    cal_valid_d  = 1'b1;
                end else begin
                    result_d = ext_q ? avg : corr_sat;
                    ready_d  = 1'b1;
                end
                cal_run_d = 1'b0;
                ext_d     = 1'b0;
                acc_d     = '0;
                conv_d    = '0;
                phase_d   = 8'h00;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Mode flags stay set through DONE so it can pick the result path; the pins drop there.
    assign bus.thresh_sel   = ext_q & (state_q != StDone);
    assign bus.do_calibrate = cal_run_q & (state_q != StDone);
    assign bus.busy         = (state_q != StIdle);
    assign bus.result       = result_q;
    assign bus.result_ready = ready_q;
    assign bus.cal_offset   = cal_offset_q;
    assign bus.cal_valid    = cal_valid_q;

endmodule

// File: tb/tb_wowa_sar_sequencer.sv
module tb_wowa_sar_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] vin = 8'h00;
    logic       force_en = 1'b0;
    logic       force_val = 1'b0;
    logic [7:0] model_cal = 8'h80;
    logic [7:0] sb[$];
    int         n_checks = 0;
    int         n_pass = 0;

    wowa_sar_sequencer_if bus ();

    wowa_sar_sequencer #(
        .SETTLE_CYCLES(4),
        .AVG_LOG2     (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Ideal comparator: input at or above threshold reads 1.
    assign bus.comp_out = force_en ? force_val : (vin >= bus.dac_set);

    function automatic logic [7:0] sat(input int v, input int c);
        int r;
        r = v - c + 128;
        if (r < 0) return 8'h00;
        if (r > 255) return 8'hFF;
        return 8'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run(input bit cal, input bit st, input bit ext, input logic [7:0] v,
                       input bit mid_pulse, input int exp_lat);
        int         n_ready;
        bit         done;
        bit         nen_bad;
        logic [7:0] exp_v;
        n_ready = 0;
        done    = 1'b0;
        nen_bad = 1'b0;
        vin     = v;
        @(negedge clk);
        bus.calib_req      = cal;
        bus.start          = st;
        bus.use_ext_thresh = ext;
        if (!cal) sb.push_back(ext ? {7'b0, force_val} : sat(int'(v), int'(model_cal)));
        @(posedge clk);
        #1;
        check("accept_busy", 32'(bus.busy), 32'd1);
        check("accept_do_calibrate", 32'(bus.do_calibrate), 32'(cal));
        @(negedge clk);
        bus.calib_req      = 1'b0;
        bus.start          = 1'b0;
        bus.use_ext_thresh = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (mid_pulse && k == 50) bus.start = 1'b1;
            if (mid_pulse && k == 51) bus.start = 1'b0;
            if (ext && k == 3) begin
                check("ext_thresh_sel", 32'(bus.thresh_sel), 32'd1);
                check("ext_dac_set", 32'(bus.dac_set), 32'd0);
            end
            if (!bus.comp_nen && !bus.busy) nen_bad = 1'b1;
            if (bus.result_ready) begin
                n_ready++;
                check("ready_latency", 32'(k), 32'(exp_lat));
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'(bus.result), 32'hFFFF_FFFF);
                end else begin
                    exp_v = sb.pop_front();
                    check("result", 32'(bus.result), 32'(exp_v));
                end
            end
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        check("run_completes", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check("ready_single_pulse", 32'(bus.result_ready), 32'd0);
        check("ready_count", 32'(n_ready), cal ? 32'd0 : 32'd1);
        check("nen_only_busy", 32'(nen_bad), 32'd0);
        if (cal) begin
            model_cal = v;
            check("cal_offset", 32'(bus.cal_offset), 32'(v));
            check("cal_valid", 32'(bus.cal_valid), 32'd1);
        end
    endtask

    initial begin
        bus.start          = 1'b0;
        bus.calib_req      = 1'b0;
        bus.use_ext_thresh = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dac_set", 32'(bus.dac_set), 32'h00);
        check("rst_thresh_sel", 32'(bus.thresh_sel), 32'd0);
        check("rst_do_calibrate", 32'(bus.do_calibrate), 32'd0);
        check("rst_comp_nen", 32'(bus.comp_nen), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result", 32'(bus.result), 32'h00);
        check("rst_result_ready", 32'(bus.result_ready), 32'd0);
        check("rst_cal_offset", 32'(bus.cal_offset), 32'h80);
        check("rst_cal_valid", 32'(bus.cal_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Uncalibrated conversion: offset 0x80 leaves the code unchanged.
        run(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 170);
        // Calibration, then corrected conversions including low-side saturation.
        run(1'b1, 1'b0, 1'b0, 8'h83, 1'b0, 0);
        run(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 170);
        run(1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 170);
        // start and calib_req together: calibration only.
        run(1'b1, 1'b1, 1'b0, 8'h70, 1'b0, 0);
        // High-side saturation with a start pulse mid-run that must be ignored.
        run(1'b0, 1'b1, 1'b0, 8'hFA, 1'b1, 170);
        // External-threshold mode, comparator forced.
        force_en  = 1'b1;
        force_val = 1'b1;
        run(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 11);
        force_val = 1'b0;
        run(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 11);
        force_en  = 1'b0;

        // Reset in the middle of a BIT phase.
        vin = 8'h5A;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_dac_active", 32'(bus.dac_set != 8'h00), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_dac_set", 32'(bus.dac_set), 32'h00);
        check("arst_thresh_sel", 32'(bus.thresh_sel), 32'd0);
        check("arst_do_calibrate", 32'(bus.do_calibrate), 32'd0);
        check("arst_comp_nen", 32'(bus.comp_nen), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_result", 32'(bus.result), 32'h00);
        check("arst_result_ready", 32'(bus.result_ready), 32'd0);
        check("arst_cal_offset", 32'(bus.cal_offset), 32'h80);
        check("arst_cal_valid", 32'(bus.cal_valid), 32'd0);
        model_cal = 8'h80;
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 170);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wowa_sar_sequencer.md
Name: wowa_sar_sequencer

Overview:
- Successive-approximation conversion controller for the wowa analog front end.
- Drives the 8-bit threshold DAC, comparator enable, calibrate and threshold-select controls, and reads back the comparator output.
- Sequences warm-up, per-bit settling, multi-conversion averaging and offset calibration.
- Sits between the TT pin interface (ui_in/uo_out) and wowa_analog.

Parameters:
- SETTLE_CYCLES, 4, cycles waited after each DAC/enable change before sampling the comparator (legal range 1..255).
- AVG_LOG2, 2, log2 of the number of conversions averaged per result (legal range 0..4).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  conversion request; level-sampled in IDLE only
- calib_req  in  1  calibration request; level-sampled in IDLE; has priority over start
- use_ext_thresh  in  1  select external-threshold mode; latched when a request is accepted
- comp_out  in  1  asynchronous comparator output (1 = input >= threshold)
- dac_set  out  8  DAC code
- thresh_sel  out  1  1 = external threshold routed to the comparator
- do_calibrate  out  1  high during a calibration run
- comp_nen  out  1  comparator enable, active-low
- busy  out  1  high in every state except IDLE
- result  out  8  last corrected result; held until the next result
- result_ready  out  1  one-cycle pulse when result updates
- cal_offset  out  8  stored calibration code
- cal_valid  out  1  high once a calibration has completed

Behaviour:
- Reset values (async):
  - Control outputs: dac_set=0x00, thresh_sel=0, do_calibrate=0, comp_nen=1, busy=0.
  - Result outputs: result=0x00, result_ready=0.
  - Calibration: cal_offset=0x80, cal_valid=0.
  - Internal state: FSM=IDLE, accumulator and counters cleared.
- Reset mid-operation aborts immediately to these values, including clearing calibration.
- comp_out passes through a 2-flop synchronizer. All samples use the synchronized value, which is cleared by reset.
- Bit phase: one phase lasts SETTLE_CYCLES+1 cycles. Its DAC/control value is applied on entry and the comparator is sampled on the last cycle. S = SETTLE_CYCLES.
- FSM states: IDLE, WARMUP, BIT, ACCUM, EXT, DONE.
  - IDLE:
    - comp_nen=1, dac_set=0.
    - If calib_req=1: accept as a calibration run (do_calibrate=1, mode forced internal).
    - Else if start=1: accept as a normal run. Latch use_ext_thresh into thresh_sel.
    - Go to WARMUP.
  - WARMUP:
    - comp_nen=0 for one phase.
    - Go to EXT if thresh_sel=1, else go to BIT with bit index 7 and code 0.
  - BIT:
    - dac_set = code | (1<<i).
    - At the sample point, if the comparator reads 1, keep the bit in code.
    - If i=0, go to ACCUM; else decrement i and stay in BIT.
  - ACCUM (1 cycle):
    - acc += code (acc is 8+AVG_LOG2 bits, no overflow possible).
    - conv_cnt++.
    - If conv_cnt = 2^AVG_LOG2, go to DONE; else go to BIT with i=7, code=0.
  - EXT:
    - One phase with dac_set=0.
    - avg = {7'b0, sample}.
    - Go to DONE with no correction.
  - DONE (1 cycle):
    - avg = acc >> AVG_LOG2.
    - Calibration run: cal_offset=avg, cal_valid=1, no result_ready.
    - Normal internal run: result = sat8(avg - cal_offset + 0x80), clamped to 0x00..0xFF.
    - External run: result = avg.
    - Non-calibration runs: result_ready=1 for this cycle.
    - In all runs: comp_nen=1, do_calibrate=0, thresh_sel=0, acc and conv_cnt cleared, go to IDLE.
- Request handling:
  - start and calib_req are ignored while busy; nothing is queued.
  - A request held high is re-accepted on the cycle after DONE.
- Latency, internal mode: with start accepted at edge 0, result_ready is high after edge (S+1)(1+8·2^AVG_LOG2)+2^AVG_LOG2+1. With defaults this is edge 170.
- Latency, external mode: result_ready is high after edge 2(S+1)+1. With defaults this is edge 11.

Test Plan:
- Default params, comparator model comp=(vin>=dac_set), vin=0x5A, start pulse -> busy for the full run, result=0x5A, result_ready a single pulse after edge 170, comp_nen low only while busy.
- calib_req with vin=0x83 -> cal_offset=0x83, cal_valid=1, no result_ready. Then start with vin=0x5A -> result=0x57.
- cal_offset=0x83 with vin=0x01 -> result=0x00 (saturation). Calibrate at vin=0x70 then convert vin=0xFA -> result=0xFF.
- Ext mode: use_ext_thresh=1, comp forced 1 -> thresh_sel=1 during the run, dac_set=0, result=0x01 pulsed after edge 11. With comp forced 0 -> result=0x00.
- Assert start and calib_req together -> calibration run only. Pulse start mid-run -> ignored and result_ready pulses once.
- Assert rst mid-BIT -> all outputs at reset values in the same cycle, cal_offset=0x80, cal_valid=0. After release, a start with vin=0x5A gives result=0x5A.
